// File: rtl/shared_reg_arbiter.sv
// Purpose : round-robin arbiter sharing one DATA_W-bit register among NUM_REQ requesters.
// Latency : req -> grant 1 edge; the owner's data lands in reg_q on each following edge it holds req.
// Backpr. : none; a requester waits in req until granted, and grants are released after MAX_HOLD writes.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high; clears all state and outputs immediately
//   req      level-sensitive request, one bit per requester
//   wdata    packed write data, requester i at [i*DATA_W +: DATA_W]
//   grant    registered one-hot grant, all-zero when idle
//   owner_id index of the current/last owner (holds after release)
//   busy     high while a grant is active
//   reg_q    shared register contents
//
// Build option: define SHARED_REG_ARB_FIXED_PRIORITY_EN to replace round-robin with
// fixed priority (lowest asserted index wins). Default build is round-robin.

module shared_reg_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]          grant,
   output logic [$clog2(NUM_REQ)-1:0]  owner_id,
   output logic                        busy,
   output logic [DATA_W-1:0]           reg_q
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int HC_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [HC_W-1:0]   hold_cnt;

   logic [ID_W-1:0]   base;
   logic [ID_W-1:0]   pick;
   logic              found;
   int                idx;

   logic              own_req;
   logic [DATA_W-1:0] own_dat;
   logic              last_write;
   logic [ID_W-1:0]   next_ptr;

`ifdef SHARED_REG_ARB_FIXED_PRIORITY_EN
   assign base = '0;
`else
   assign base = ptr;
`endif

   // Search req starting at base, wrapping around; first hit wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(base) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   assign own_req    = req[owner_id];
   assign own_dat    = wdata[int'(owner_id)*DATA_W +: DATA_W];
   // This edge's write is the MAX_HOLD-th one for the current grant.
   assign last_write = (int'(hold_cnt) == MAX_HOLD - 1);
   assign next_ptr   = (int'(owner_id) == NUM_REQ - 1) ? '0 : owner_id + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         owner_id <= '0;
         busy     <= 1'b0;
         reg_q    <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant    <= NUM_REQ'(1) << pick;
                  owner_id <= pick;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (own_req) begin
                  reg_q    <= own_dat;
                  hold_cnt <= hold_cnt + 1'b1;
               end
               // Owner let go, or has used its full allowance: give up the register.
               if (!own_req || last_write) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= next_ptr;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

   localparam int MAXH = 4;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  grant;
   logic [1:0]  owner_id;
   logic        busy;
   logic [7:0]  reg_q;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      logic [7:0] q;
   } exp_t;

   exp_t sb[$];

   // Reference model state: ms 0=idle 1=grant 2=release.
   int         ms, mptr, mown, mhold;
   logic [3:0] mg;
   logic       mb;
   logic [7:0] mq;

   shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(MAXH)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .wdata    (wdata),
      .grant    (grant),
      .owner_id (owner_id),
      .busy     (busy),
      .reg_q    (reg_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      ms = 0; mptr = 0; mown = 0; mhold = 0;
      mg = 4'b0; mb = 1'b0; mq = 8'h00;
   endfunction

   function automatic void model_step(input logic [3:0] r, input logic [31:0] wd);
      int base;
      bit hit;
      hit = 0;
`ifdef SHARED_REG_ARB_FIXED_PRIORITY_EN
      base = 0;
`else
      base = mptr;
`endif
      case (ms)
         0: begin
            for (int k = 0; k < 4; k++) begin
               if (!hit && r[(base + k) % 4]) begin
                  hit   = 1;
                  mown  = (base + k) % 4;
                  mg    = 4'b0001 << mown;
                  mb    = 1'b1;
                  mhold = 0;
                  ms    = 1;
               end
            end
         end
         1: begin
            if (r[mown]) begin
               mq = wd[mown*8 +: 8];
               mhold++;
            end
            if (!r[mown] || mhold == MAXH) begin
               ms   = 2;
               mg   = 4'b0;
               mb   = 1'b0;
               mptr = (mown + 1) % 4;
            end
         end
         default: ms = 0;
      endcase
   endfunction

   function automatic logic [31:0] wd4(input logic [7:0] d0, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [7:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   // One clock: drive inputs, predict, let the edge pass, compare against the prediction.
   task automatic cyc(input logic [3:0] r, input logic [31:0] wd);
      exp_t e;
      exp_t got;
      req   = r;
      wdata = wd;
      model_step(r, wd);
      e.g = mg;
      e.o = 2'(mown);
      e.b = mb;
      e.q = mq;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      chk("grant",    {28'b0, grant},    {28'b0, got.g});
      chk("owner_id", {30'b0, owner_id}, {30'b0, got.o});
      chk("busy",     {31'b0, busy},     {31'b0, got.b});
      chk("reg_q",    {24'b0, reg_q},    {24'b0, got.q});
   endtask

   // Reset pulse placed between edges.
   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      chk("rst_grant", {28'b0, grant}, 32'h0);
      chk("rst_busy",  {31'b0, busy},  32'h0);
      chk("rst_reg_q", {24'b0, reg_q}, 32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b0;
      req   = 4'b0;
      wdata = 32'h0;
      model_reset();

      // 1: reset with all requests high, then a single write from requester 0
      #1;
      reset = 1'b1;
      req   = 4'b1111;
      @(posedge clock);
      #1;
      chk("t1_rst_grant", {28'b0, grant},    32'h0);
      chk("t1_rst_busy",  {31'b0, busy},     32'h0);
      chk("t1_rst_reg_q", {24'b0, reg_q},    32'h0);
      chk("t1_rst_owner", {30'b0, owner_id}, 32'h0);
      reset = 1'b0;
      cyc(4'b0001, wd4(8'hA5, 8'h00, 8'h00, 8'h00));
      chk("t1_grant0", {28'b0, grant}, 32'h1);
      cyc(4'b0001, wd4(8'hA5, 8'h00, 8'h00, 8'h00));
      chk("t1_reg_a5", {24'b0, reg_q}, 32'hA5);
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);

      // 2: requester 2 holds req, data counts up each cycle
      for (int k = 0; k <= 6; k++) begin
         cyc(4'b0100, wd4(8'h00, 8'h00, 8'(k), 8'h00));
         if (k == 4) begin
            chk("t2_reg_after_4", {24'b0, reg_q}, 32'h04);
            chk("t2_grant_drop",  {28'b0, grant}, 32'h0);
         end
         if (k == 6) chk("t2_regrant", {28'b0, grant}, 32'h4);
      end
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);

      // 3: everyone requesting continuously
      pulse_reset();
      for (int i = 1; i <= 26; i++) begin
         cyc(4'b1111, wd4(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)));
         if (i == 6) chk("t3_gap", {28'b0, grant}, 32'h0);
`ifdef SHARED_REG_ARB_FIXED_PRIORITY_EN
         if (i == 7) chk("t3_second_owner", {28'b0, grant}, 32'h1);
`else
         if (i == 7) chk("t3_second_owner", {28'b0, grant}, 32'h2);
`endif
         if (i == 25) chk("t3_wrap_owner", {28'b0, grant}, 32'h1);
      end
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);

      // 4: owner 1 drops early; pointer moves past it to 2, so 3 beats 0
      pulse_reset();
      cyc(4'b0010, wd4(8'h00, 8'h00, 8'h00, 8'h00));
      cyc(4'b0010, wd4(8'h00, 8'h11, 8'h00, 8'h00));
      cyc(4'b0010, wd4(8'h00, 8'h22, 8'h00, 8'h00));
      chk("t4_reg_22", {24'b0, reg_q}, 32'h22);
      cyc(4'b1001, wd4(8'h0A, 8'h00, 8'h00, 8'h3A));
      chk("t4_release", {31'b0, busy}, 32'h0);
      cyc(4'b1001, wd4(8'h0A, 8'h00, 8'h00, 8'h3A));
      cyc(4'b1001, wd4(8'h0A, 8'h00, 8'h00, 8'h3A));
`ifdef SHARED_REG_ARB_FIXED_PRIORITY_EN
      chk("t4_next_grant", {28'b0, grant}, 32'h1);
`else
      chk("t4_next_grant", {28'b0, grant}, 32'h8);
      chk("t4_next_owner", {30'b0, owner_id}, 32'h3);
`endif

      // 5: reset lands between edges mid-grant
      cyc(4'b1001, wd4(8'h0B, 8'h00, 8'h00, 8'h33));
      pulse_reset();
      cyc(4'b1000, wd4(8'h00, 8'h00, 8'h00, 8'h44));
      chk("t5_grant3", {28'b0, grant},    32'h8);
      chk("t5_owner3", {30'b0, owner_id}, 32'h3);
      cyc(4'b0000, 32'h0);
      cyc(4'b0000, 32'h0);

      // 6: one-cycle pulse on req[1]
      cyc(4'b0010, wd4(8'h00, 8'h77, 8'h00, 8'h00));
      chk("t6_grant1", {28'b0, grant}, 32'h2);
      chk("t6_busy1",  {31'b0, busy},  32'h1);
      cyc(4'b0000, wd4(8'h00, 8'h77, 8'h00, 8'h00));
      chk("t6_grant_off", {28'b0, grant}, 32'h0);
      chk("t6_reg_hold",  {24'b0, reg_q}, 32'h0);
      cyc(4'b0000, 32'h0);

      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
